// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared widths and fetch FSM state encoding for the front end.
// Rev 1.0
`default_nettype none

package ifetch_pkg;

  localparam int DEF_ADDR_WIDTH  = 14;
  localparam int DEF_INSTR_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH  = 4;

  localparam logic [1:0] IF_IDLE  = 2'd0;
  localparam logic [1:0] IF_WAIT  = 2'd1;
  localparam logic [1:0] IF_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = IF_IDLE,
    ST_WAIT  = IF_WAIT,
    ST_DRAIN = IF_DRAIN
  } if_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with clear and occupancy count.
// Rev 1.0
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 30,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_clear,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  // Clear dominates so a same-cycle push or pop is ignored.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Storage is not reset; gating on occupancy keeps the head at zero when empty.
  assign o_rdata = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/ifetch_unit.sv
// ifetch_unit: one-outstanding-request fetch engine feeding a decode FIFO.
// Rev 1.0
`default_nettype none

module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int DEPTH       = DEF_FIFO_DEPTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  input  logic                   i_pc_valid,
  output logic                   o_pc_ready,
  output logic                   o_mem_req,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  input  logic                   i_mem_ack,
  input  logic [INSTR_WIDTH-1:0] i_mem_rdata,
  input  logic                   i_flush,
  output logic                   o_instr_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_instr_pc,
  input  logic                   i_instr_ready
);

  localparam int FW = ADDR_WIDTH + INSTR_WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;

  if_state_t             r_state;
  if_state_t             w_state_nxt;
  logic                  r_mem_req;
  logic                  w_mem_req_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [ADDR_WIDTH-1:0] w_mem_addr_nxt;
  logic                  w_push;
  logic                  w_pop;
  logic [FW-1:0]         w_fifo_rdata;
  logic [CW-1:0]         w_count;

  assign o_pc_ready    = (r_state == ST_IDLE) && (w_count < CW'(DEPTH)) && !i_flush;
  assign o_instr_valid = (w_count != '0);
  assign w_pop         = o_instr_valid && i_instr_ready && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_push         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_pc_valid && o_pc_ready) begin
          w_state_nxt    = ST_WAIT;
          w_mem_req_nxt  = 1'b1;
          w_mem_addr_nxt = i_pc;
        end
      end
      ST_WAIT: begin
        if (i_mem_ack) begin
          w_state_nxt   = ST_IDLE;
          w_mem_req_nxt = 1'b0;
          w_push        = !i_flush;
        end else if (i_flush) begin
          // The request cannot be withdrawn; swallow its eventual ack.
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (i_mem_ack) begin
          w_state_nxt   = ST_IDLE;
          w_mem_req_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (i_flush),
    .i_wdata ({r_mem_addr, i_mem_rdata}),
    .o_rdata (w_fifo_rdata),
    .o_count (w_count)
  );

  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_mem_addr;
  assign o_instr_pc = w_fifo_rdata[FW-1:INSTR_WIDTH];
  assign o_instr    = w_fifo_rdata[INSTR_WIDTH-1:0];

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: directed bench for ifetch_unit with hand-computed expectations.
// Rev 1.0
`default_nettype none

module tb_ifetch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [13:0] i_pc;
  logic        i_pc_valid;
  logic        o_pc_ready;
  logic        o_mem_req;
  logic [13:0] o_mem_addr;
  logic        i_mem_ack;
  logic [15:0] i_mem_rdata;
  logic        i_flush;
  logic        o_instr_valid;
  logic [15:0] o_instr;
  logic [13:0] o_instr_pc;
  logic        i_instr_ready;

  int vectors = 0;
  int errors  = 0;

  ifetch_unit dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_pc          (i_pc),
    .i_pc_valid    (i_pc_valid),
    .o_pc_ready    (o_pc_ready),
    .o_mem_req     (o_mem_req),
    .o_mem_addr    (o_mem_addr),
    .i_mem_ack     (i_mem_ack),
    .i_mem_rdata   (i_mem_rdata),
    .i_flush       (i_flush),
    .o_instr_valid (o_instr_valid),
    .o_instr       (o_instr),
    .o_instr_pc    (o_instr_pc),
    .i_instr_ready (i_instr_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Accept addr, ack after `delay` idle cycles; leaves the pushed entry at the head if FIFO was empty.
  task automatic fetch(input logic [13:0] addr, input logic [15:0] data, input int delay);
    i_pc       = addr;
    i_pc_valid = 1'b1;
    #1;
    chk("fetch_pc_ready", 32'(o_pc_ready), 32'd1);
    tick();
    i_pc_valid = 1'b0;
    #1;
    chk("fetch_req", 32'(o_mem_req), 32'd1);
    chk("fetch_addr", 32'(o_mem_addr), 32'(addr));
    for (int k = 0; k < delay; k++) tick();
    i_mem_ack   = 1'b1;
    i_mem_rdata = data;
    tick();
    i_mem_ack   = 1'b0;
    #1;
    chk("fetch_req_clr", 32'(o_mem_req), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst_n       = 1'b0;
    i_pc          = '0;
    i_pc_valid    = 1'b0;
    i_mem_ack     = 1'b0;
    i_mem_rdata   = '0;
    i_flush       = 1'b0;
    i_instr_ready = 1'b0;
    #1;
    chk("rst_mem_req", 32'(o_mem_req), 32'd0);
    chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_instr_valid", 32'(o_instr_valid), 32'd0);
    chk("rst_instr", 32'(o_instr), 32'd0);
    chk("rst_instr_pc", 32'(o_instr_pc), 32'd0);
    chk("rst_pc_ready", 32'(o_pc_ready), 32'd1);
    #11;
    i_rst_n = 1'b1;
    tick();

    // Single fetch: accept at edge N, ack in N+1, head valid in N+2.
    i_pc       = 14'h0010;
    i_pc_valid = 1'b1;
    #1;
    chk("t1_pc_ready", 32'(o_pc_ready), 32'd1);
    tick();
    i_pc_valid = 1'b0;
    #1;
    chk("t1_req", 32'(o_mem_req), 32'd1);
    chk("t1_addr", 32'(o_mem_addr), 32'h0010);
    chk("t1_pc_ready_wait", 32'(o_pc_ready), 32'd0);
    chk("t1_valid_early", 32'(o_instr_valid), 32'd0);
    i_mem_ack   = 1'b1;
    i_mem_rdata = 16'hA5A5;
    tick();
    i_mem_ack = 1'b0;
    #1;
    chk("t1_valid", 32'(o_instr_valid), 32'd1);
    chk("t1_instr", 32'(o_instr), 32'hA5A5);
    chk("t1_instr_pc", 32'(o_instr_pc), 32'h0010);
    chk("t1_pc_ready_back", 32'(o_pc_ready), 32'd1);
    chk("t1_req_clr", 32'(o_mem_req), 32'd0);
    i_instr_ready = 1'b1;
    tick();
    i_instr_ready = 1'b0;
    #1;
    chk("t1_popped", 32'(o_instr_valid), 32'd0);

    // Fill with decode stalled, then drain in order.
    for (int i = 0; i < 4; i++) fetch(14'(i), 16'h1000 + 16'(i), 0);
    chk("t2_full_pc_ready", 32'(o_pc_ready), 32'd0);
    chk("t2_head_pc", 32'(o_instr_pc), 32'h0000);
    i_instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_pop_valid", 32'(o_instr_valid), 32'd1);
      chk("t2_pop_instr", 32'(o_instr), 32'h1000 + 32'(i));
      chk("t2_pop_pc", 32'(o_instr_pc), 32'(i));
      tick();
    end
    i_instr_ready = 1'b0;
    #1;
    chk("t2_empty", 32'(o_instr_valid), 32'd0);
    chk("t2_pc_ready", 32'(o_pc_ready), 32'd1);

    // Slow memory: request held for 5 cycles.
    i_pc       = 14'h0020;
    i_pc_valid = 1'b1;
    tick();
    i_pc_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_req_hold", 32'(o_mem_req), 32'd1);
      chk("t3_addr_hold", 32'(o_mem_addr), 32'h0020);
      chk("t3_pc_ready_low", 32'(o_pc_ready), 32'd0);
      chk("t3_no_valid", 32'(o_instr_valid), 32'd0);
      tick();
    end
    i_mem_ack   = 1'b1;
    i_mem_rdata = 16'hBEEF;
    tick();
    i_mem_ack = 1'b0;
    #1;
    chk("t3_valid", 32'(o_instr_valid), 32'd1);
    chk("t3_instr", 32'(o_instr), 32'hBEEF);
    chk("t3_instr_pc", 32'(o_instr_pc), 32'h0020);
    i_instr_ready = 1'b1;
    tick();
    i_instr_ready = 1'b0;
    #1;
    chk("t3_one_push", 32'(o_instr_valid), 32'd0);

    // Flush while WAIT with two buffered entries.
    fetch(14'h0030, 16'h0001, 0);
    fetch(14'h0031, 16'h0002, 0);
    i_pc       = 14'h0040;
    i_pc_valid = 1'b1;
    tick();
    i_pc_valid = 1'b0;
    i_flush    = 1'b1;
    #1;
    chk("t4_pc_ready_flush", 32'(o_pc_ready), 32'd0);
    tick();
    i_flush = 1'b0;
    #1;
    chk("t4_flushed", 32'(o_instr_valid), 32'd0);
    chk("t4_drain_req", 32'(o_mem_req), 32'd1);
    chk("t4_drain_pc_ready", 32'(o_pc_ready), 32'd0);
    tick();
    tick();
    i_mem_ack   = 1'b1;
    i_mem_rdata = 16'hDEAD;
    tick();
    i_mem_ack = 1'b0;
    #1;
    chk("t4_discard", 32'(o_instr_valid), 32'd0);
    chk("t4_req_clr", 32'(o_mem_req), 32'd0);
    chk("t4_pc_ready", 32'(o_pc_ready), 32'd1);
    fetch(14'h0100, 16'h1234, 0);
    chk("t4_next_valid", 32'(o_instr_valid), 32'd1);
    chk("t4_next_instr", 32'(o_instr), 32'h1234);
    chk("t4_next_pc", 32'(o_instr_pc), 32'h0100);
    i_instr_ready = 1'b1;
    tick();
    i_instr_ready = 1'b0;

    // Flush, ack and pop in one cycle.
    fetch(14'h0050, 16'h5555, 0);
    i_pc       = 14'h0051;
    i_pc_valid = 1'b1;
    tick();
    i_pc_valid    = 1'b0;
    i_mem_ack     = 1'b1;
    i_mem_rdata   = 16'h6666;
    i_flush       = 1'b1;
    i_instr_ready = 1'b1;
    tick();
    i_mem_ack     = 1'b0;
    i_flush       = 1'b0;
    i_instr_ready = 1'b0;
    #1;
    chk("t5_empty", 32'(o_instr_valid), 32'd0);
    chk("t5_req_clr", 32'(o_mem_req), 32'd0);
    chk("t5_idle_ready", 32'(o_pc_ready), 32'd1);
    fetch(14'h0060, 16'h7777, 0);
    chk("t5_after_pc", 32'(o_instr_pc), 32'h0060);
    chk("t5_after_instr", 32'(o_instr), 32'h7777);
    i_instr_ready = 1'b1;
    tick();
    i_instr_ready = 1'b0;

    // Async reset mid-WAIT with one entry buffered.
    fetch(14'h0080, 16'h8888, 0);
    i_pc       = 14'h0070;
    i_pc_valid = 1'b1;
    tick();
    i_pc_valid = 1'b0;
    #1;
    chk("t6_pre_req", 32'(o_mem_req), 32'd1);
    chk("t6_pre_valid", 32'(o_instr_valid), 32'd1);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("t6_req_async", 32'(o_mem_req), 32'd0);
    chk("t6_valid_async", 32'(o_instr_valid), 32'd0);
    chk("t6_pc_ready", 32'(o_pc_ready), 32'd1);
    #2;
    i_rst_n = 1'b1;
    tick();
    fetch(14'h0090, 16'h9999, 0);
    chk("t6_after_valid", 32'(o_instr_valid), 32'd1);
    chk("t6_after_instr", 32'(o_instr), 32'h9999);
    chk("t6_after_pc", 32'(o_instr_pc), 32'h0090);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ifetch_unit.md
# ifetch_unit

- Instruction-fetch front end that consumes fetch addresses produced by the program counter and returns instructions to decode.
- Data path: accepts a PC value over a valid/ready handshake, issues one request at a time to instruction memory over a req/ack handshake, and buffers returned instructions with their PC in a small FIFO.
- The FIFO output feeds decode through a valid/ready handshake.
- A flush input discards all buffered and in-flight fetches on a branch or jump.

## Interface
- ADDR_WIDTH, 14, width of the PC and instruction-memory address
- INSTR_WIDTH, 16, instruction word width
- DEPTH, 4, FIFO entries (power of two, ≥2)

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset, asynchronous assert, active-low
- i_pc  in  ADDR_WIDTH  fetch address from the PC
- i_pc_valid  in  1  i_pc holds a fetch address
- o_pc_ready  out  1  address accepted this cycle when high with i_pc_valid; the PC advances only on accept
- o_mem_req  out  1  memory request outstanding
- o_mem_addr  out  ADDR_WIDTH  request address, stable while o_mem_req high
- i_mem_ack  in  1  memory returns data this cycle, sampled only while o_mem_req high
- i_mem_rdata  in  INSTR_WIDTH  instruction word, valid with i_mem_ack
- i_flush  in  1  discard all fetches (branch/jump taken)
- o_instr_valid  out  1  FIFO head valid
- o_instr  out  INSTR_WIDTH  FIFO head instruction
- o_instr_pc  out  ADDR_WIDTH  FIFO head address
- i_instr_ready  in  1  decode pops the head when high with o_instr_valid

## Operation
FSM states: IDLE, WAIT, DRAIN.

- **IDLE**
  - o_pc_ready = (state==IDLE) && (count < DEPTH) && !i_flush.
  - On accept: latch i_pc into o_mem_addr, set o_mem_req, go to WAIT.
- **WAIT**
  - Hold o_mem_req and o_mem_addr.
  - On i_mem_ack without i_flush: push {o_mem_addr, i_mem_rdata}, clear o_mem_req, go to IDLE.
  - On i_flush without ack: go to DRAIN. o_mem_req stays high, because the memory request cannot be withdrawn.
  - On i_flush and ack in the same cycle: drop the data, clear o_mem_req, go to IDLE.
- **DRAIN**
  - Keep o_mem_req high until i_mem_ack.
  - On ack: discard the data, clear o_mem_req, go to IDLE.
  - i_flush in DRAIN has no additional effect.
- **FIFO**
  - count ranges 0..DEPTH.
  - A slot is reserved at accept (count < DEPTH is checked at accept), so a push never meets a full FIFO.
  - Push and pop in the same cycle: count is unchanged.
  - Pointers wrap modulo DEPTH.
- **Flush**
  - i_flush clears count and pointers at the next edge. Any pop in the same cycle is ignored.
  - o_instr_valid is low in the following cycle.

## Timing
- Reset values:
  - State IDLE, count 0, pointers 0.
  - o_mem_req 0, o_mem_addr 0, o_instr_valid 0, o_instr 0, o_instr_pc 0.
  - o_pc_ready 1 (combinational from reset state).
- Reset mid-request drops o_mem_req asynchronously. The memory must tolerate an abandoned request.
- Accept at edge N: o_mem_req is high from cycle N+1.
- Ack in cycle N+1: entry pushed at edge N+2, o_instr_valid high in cycle N+2, o_pc_ready high again in cycle N+2.
- Minimum fetch latency is 2 cycles. Peak throughput is one instruction per 2 cycles with single-cycle ack.
- o_instr, o_instr_pc and o_instr_valid are driven from registered FIFO state. There is no combinational path from i_mem_* to o_instr*.
- o_instr_valid with its data is held stable until popped or flushed.
- Combinational inputs to o_pc_ready are state, count and i_flush only. It does not depend on i_pc_valid.

## Structure
- Shared package `ifetch_pkg`:
  - State localparams IF_IDLE=2'd0, IF_WAIT=2'd1, IF_DRAIN=2'd2.
  - Default ADDR_WIDTH/INSTR_WIDTH constants, shared with pc and decode.
- Sub-module `sync_fifo`:
  - Parameterised width (ADDR_WIDTH+INSTR_WIDTH) and DEPTH.
  - Push, pop, clear and count ports, async active-low reset.
- FSM and handshake logic stay in ifetch_unit.

## Test plan
- **Reset then single fetch:** i_pc=0x0010, valid one cycle; ack in next cycle with rdata=0xA5A5 → o_instr_valid in cycle N+2 with o_instr=0xA5A5, o_instr_pc=0x0010.
- **Fill with decode stalled:** i_instr_ready=0, 4 fetches 0x0..0x3 each acked immediately → o_pc_ready low after the 4th accept. Raise ready → pops in order 0..3, then o_pc_ready returns high.
- **Slow memory:** ack delayed 5 cycles → o_mem_req and o_mem_addr stable for all 5 cycles, o_pc_ready low throughout, one push on the ack.
- **Flush during WAIT:** FIFO holds 2 entries, request 0x0040 outstanding, i_flush pulse → FIFO empty next cycle. Ack 3 cycles later: data discarded, no o_instr_valid. Next accept of 0x0100 returns normally.
- **Flush coincident with ack and pop:** all three in the same cycle → count 0, no push, state IDLE next cycle.
- **Async reset mid-WAIT:** i_rst_n low between edges → o_mem_req and o_instr_valid drop immediately. After release, o_pc_ready=1 and a fetch completes normally.
